// File: rtl/cordic_pkg.sv
// Shared constants and result record for the CORDIC vectoring arbiter.
package cordic_pkg;

    localparam int          CORDIC_LAT = 17;
    localparam int          ANGLE_FRAC = 20;
    localparam logic [31:0] DEG45      = 32'h02D_00000;

    // Record widths cover the largest supported configuration (NREQ <= 8, W/AW <= 32).
    localparam int RES_IDW = 3;
    localparam int RES_W   = 32;
    localparam int RES_AW  = 32;

    typedef struct packed {
        logic [RES_IDW-1:0] id;
        logic [RES_W-1:0]   xf;
        logic [RES_W-1:0]   yf;
        logic [RES_AW-1:0]  angle;
    } cordic_res_t;

endpackage

// File: rtl/cordic_vec_arbiter_if.sv
// Requester and result handshake bundle; master = requesters/consumer, slave = arbiter.
interface cordic_vec_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int AW   = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [W-1:0]      res_xf;
    logic [W-1:0]      res_yf;
    logic [AW-1:0]     res_angle;

    modport master (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_id, res_xf, res_yf, res_angle
    );

    modport slave (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_id, res_xf, res_yf, res_angle
    );
endinterface

// File: rtl/cordic_res_fifo.sv
// Result FIFO: memory plus a registered output stage (rd_data/rd_valid).
module cordic_res_fifo #(
    parameter int DEPTH = 32,
    parameter int DW    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DW-1:0]               wr_data,
    input  logic                        rd_en,
    output logic [DW-1:0]               rd_data,
    output logic                        rd_valid,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH+2)-1:0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 2);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   mem_cnt;
    logic          pop, load;

    // The output stage refills whenever it is empty or being popped this cycle.
    assign pop   = rd_en & rd_valid;
    assign load  = (mem_cnt != '0) && (!rd_valid || pop);
    assign full  = (mem_cnt == (PW+1)'(DEPTH));
    assign count = CW'(mem_cnt) + CW'(rd_valid);
    assign empty = (count == '0);

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                rd_data  <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
            mem_cnt <= mem_cnt + (PW+1)'(wr_en) - (PW+1)'(load);
        end
    end
endmodule

// File: rtl/cordic_vec_arbiter.sv
// Round-robin front end and ID tag pipe for a shared pipelined CORDIC vectoring core.
module cordic_vec_arbiter
    import cordic_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int W          = 32,
    parameter int AW         = 32,
    parameter int CORE_LAT   = CORDIC_LAT,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_vec_arbiter_if.slave  bus,
    output logic [W-1:0]         core_x0,
    output logic [W-1:0]         core_y0,
    input  logic [W-1:0]         core_xf,
    input  logic [W-1:0]         core_yf,
    input  logic [AW-1:0]        core_angle,
    output logic                 busy
);
    localparam int IDW  = $clog2(NREQ);
    localparam int OCCW = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0]              rr_ptr, winner, cand;
    logic                        found, can_issue, accept, pop;
    logic [NREQ-1:0]             rdy;
    logic [OCCW-1:0]             occ;
    logic [CORE_LAT:1]           vld_pipe;
    logic [CORE_LAT:1][IDW-1:0]  id_pipe;
    int                          idx;

    cordic_res_t                 wr_rec, rd_rec;
    logic                        fifo_wr, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH+2)-1:0] fifo_cnt;
    logic                        unused_fifo;

    // Credit is taken from registered occupancy only, so a same-cycle pop never frees a slot.
    assign can_issue = (occ < OCCW'(FIFO_DEPTH));
    assign pop       = bus.res_valid & bus.res_ready;

    // Round-robin search starting at rr_ptr; grant suppressed while in reset.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        accept = found & can_issue & rst;
        rdy    = '0;
        if (accept) rdy[winner] = 1'b1;
    end

    assign bus.req_ready = rdy;
    assign core_x0 = accept ? bus.req_x[int'(winner)*W +: W] : '0;
    assign core_y0 = accept ? bus.req_y[int'(winner)*W +: W] : '0;
    assign busy    = (occ != '0);

    // Round-robin pointer and occupancy (tag pipe + FIFO) bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (accept) rr_ptr <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Tag pipe shifts every cycle, matched to the core latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[CORE_LAT-1:1], accept};
            id_pipe  <= {id_pipe[CORE_LAT-1:1], winner};
        end
    end

    assign fifo_wr = vld_pipe[CORE_LAT];
    assign wr_rec  = '{id:    RES_IDW'(id_pipe[CORE_LAT]),
                       xf:    RES_W'(core_xf),
                       yf:    RES_W'(core_yf),
                       angle: RES_AW'(core_angle)};

    cordic_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    ($bits(cordic_res_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fifo_wr),
        .wr_data  (wr_rec),
        .rd_en    (bus.res_ready),
        .rd_data  (rd_rec),
        .rd_valid (bus.res_valid),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign bus.res_id    = rd_rec.id[IDW-1:0];
    assign bus.res_xf    = rd_rec.xf[W-1:0];
    assign bus.res_yf    = rd_rec.yf[W-1:0];
    assign bus.res_angle = rd_rec.angle[AW-1:0];

    // Status bits and record padding that nothing downstream consumes.
    assign unused_fifo = ^{fifo_cnt, fifo_full, fifo_empty, rd_rec};
endmodule

// File: tb/tb_cordic_vec_arbiter.sv
// Directed bench for cordic_vec_arbiter with a behavioural 17-stage vectoring core.
module tb_cordic_vec_arbiter;
    import cordic_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int AW   = 32;
    localparam int LAT  = 17;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cordic_vec_arbiter_if #(.NREQ(NREQ), .W(W), .AW(AW)) bus();

    logic [W-1:0]  core_x0, core_y0, core_xf, core_yf;
    logic [AW-1:0] core_angle;
    logic          busy;

    cordic_vec_arbiter #(
        .NREQ(NREQ), .W(W), .AW(AW), .CORE_LAT(LAT), .FIFO_DEPTH(32)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .core_x0(core_x0), .core_y0(core_y0),
        .core_xf(core_xf), .core_yf(core_yf), .core_angle(core_angle),
        .busy(busy)
    );

    // Core reference: magnitude (gain-compensated), small residual, angle in 12.20 degrees.
    function automatic logic [31:0] f_xf(input logic signed [31:0] x, input logic signed [31:0] y);
        real r;
        r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        return 32'($rtoi(r + 0.5));
    endfunction

    function automatic logic [31:0] f_yf(input logic signed [31:0] x, input logic signed [31:0] y);
        return 32'(((x ^ y) & 3) - 1);
    endfunction

    function automatic logic [31:0] f_ang(input logic signed [31:0] x, input logic signed [31:0] y);
        real a;
        a = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979;
        if (a < 0.0) a = a + 360.0;
        return 32'($rtoi(a * 1048576.0 + 0.5));
    endfunction

    logic [W-1:0] cx [1:LAT];
    logic [W-1:0] cy [1:LAT];

    always @(posedge clk) begin
        for (int i = LAT; i > 1; i--) begin
            cx[i] <= cx[i-1];
            cy[i] <= cy[i-1];
        end
        cx[1] <= core_x0;
        cy[1] <= core_y0;
    end

    assign core_xf    = f_xf(cx[LAT], cy[LAT]);
    assign core_yf    = f_yf(cx[LAT], cy[LAT]);
    assign core_angle = f_ang(cx[LAT], cy[LAT]);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y);
        bus.req_x[i*W +: W] = x;
        bus.req_y[i*W +: W] = y;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Counts edges after the accept edge until res_valid shows; bounded.
    task automatic wait_res(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.res_valid) break;
        end
    endtask

    // The FIFO must never see a write while full.
    always @(negedge clk) begin
        if (rst && dut.fifo_full && dut.fifo_wr) chk("ovf_write_when_full", 1, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    int rx [NREQ];
    int ry [NREQ];

    initial begin
        int n, k, yv, d, acc, stale;

        // ---- reset state, with requests pending ----
        bus.req_valid = 4'hF;
        bus.res_ready = 1'b0;
        bus.req_x = '0;
        bus.req_y = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(11 + i), 32'(5));
        #3;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_x0", core_x0, 0);
        chk("rst_core_y0", core_y0, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_res_xf", bus.res_xf, 0);
        chk("rst_res_angle", bus.res_angle, 0);
        do_reset();

        // ---- single request from requester 2 ----
        @(negedge clk);
        set_req(2, 32'd1000, 32'd1000);
        bus.req_valid = 4'b0100;
        #1;
        chk("t1_ready", bus.req_ready, 4'b0100);
        chk("t1_core_x0", core_x0, 1000);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_res(n);
        chk("t1_latency", n, 18);
        chk("t1_id", bus.res_id, 2);
        d = int'(bus.res_angle) - int'(DEG45);
        chk("t1_angle_tol", (d >= -16 && d <= 16), 1);
        chk("t1_angle", bus.res_angle, f_ang(1000, 1000));
        chk("t1_xf", bus.res_xf, 1414);
        yv = $signed(bus.res_yf);
        chk("t1_yf_tol", (yv >= -2 && yv <= 2), 1);
        @(negedge clk) bus.res_ready = 1'b1;
        @(negedge clk) bus.res_ready = 1'b0;
        #1;
        chk("t1_popped", bus.res_valid, 0);
        chk("t1_idle", busy, 0);

        // ---- all four streaming, full throughput ----
        do_reset();
        bus.res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rx[i] = 100 * (i + 1);
            ry[i] = -37 * i;
            set_req(i, 32'(rx[i]), 32'(ry[i]));
        end
        bus.req_valid = 4'hF;
        for (int c = 0; c < 126; c++) begin
            if (c == 100) bus.req_valid = '0;
            #1;
            if (c < 100) chk("rr_grant", bus.req_ready, 4'b1 << (c % 4));
            if (c >= 19 && c < 119) begin
                k = c - 19;
                chk("rr_res_valid", bus.res_valid, 1);
                chk("rr_res_id", bus.res_id, k % 4);
                chk("rr_res_xf", bus.res_xf, f_xf(rx[k%4], ry[k%4]));
            end
            if (c == 18 || c == 119) chk("rr_res_edge", bus.res_valid, 0);
            @(negedge clk);
        end
        chk("rr_drained", busy, 0);

        // ---- credit limit under backpressure ----
        do_reset();
        set_req(0, 32'd7, 32'd24);
        bus.req_valid = 4'b0001;
        acc = 0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (bus.req_ready[0]) acc++;
            @(negedge clk);
        end
        #1;
        chk("cr_accepts", acc, 32);
        chk("cr_stalled", bus.req_ready, 0);
        chk("cr_res_valid", bus.res_valid, 1);
        chk("cr_res_xf", bus.res_xf, 25);
        bus.res_ready = 1'b1;
        #1 chk("cr_no_same_cycle", bus.req_ready, 0);
        @(negedge clk) bus.res_ready = 1'b0;
        #1 chk("cr_one_credit", bus.req_ready, 4'b0001);
        @(negedge clk);
        #1 chk("cr_full_again", bus.req_ready, 0);
        chk("cr_busy", busy, 1);

        // ---- alternating 1 and 3 with rr_ptr at 2 ----
        do_reset();
        bus.res_ready = 1'b1;
        set_req(1, 32'd3, 32'd4);
        set_req(3, 32'd6, 32'd8);
        bus.req_valid = 4'b0010;
        #1 chk("alt_setup", bus.req_ready, 4'b0010);
        @(negedge clk);
        bus.req_valid = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            #1 chk("alt_grant", bus.req_ready, (c % 2 == 0) ? 4'b1000 : 4'b0010);
            @(negedge clk);
        end
        bus.req_valid = '0;

        // ---- asynchronous reset with 10 in flight and 5 queued ----
        do_reset();
        set_req(2, 32'd3, 32'd4);
        bus.req_valid = 4'b0100;
        repeat (15) @(negedge clk);
        bus.req_valid = '0;
        repeat (7) @(negedge clk);
        #1;
        chk("ar_queued", dut.u_fifo.count, 5);
        chk("ar_busy_before", busy, 1);
        bus.req_valid = 4'b0100;
        #1 chk("ar_ready_before", bus.req_ready, 4'b0100);
        #1 rst = 1'b0;
        #1;
        chk("ar_res_valid", bus.res_valid, 0);
        chk("ar_req_ready", bus.req_ready, 0);
        chk("ar_busy", busy, 0);
        chk("ar_core_x0", core_x0, 0);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.res_valid) stale++;
        end
        chk("ar_no_stale", stale, 0);
        set_req(3, -32'sd300, 32'sd400);
        bus.req_valid = 4'b1000;
        #1 chk("ar_new_ready", bus.req_ready, 4'b1000);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_res(n);
        chk("ar_new_latency", n, 18);
        chk("ar_new_id", bus.res_id, 3);
        chk("ar_new_xf", bus.res_xf, 500);
        chk("ar_new_angle", bus.res_angle, f_ang(-300, 400));

        // ---- (0,0) then (-500,0) from requester 1, in order ----
        do_reset();
        set_req(1, 32'd0, 32'd0);
        bus.req_valid = 4'b0010;
        #1 chk("ord_ready0", bus.req_ready, 4'b0010);
        @(posedge clk);
        #1 set_req(1, -32'sd500, 32'd0);
        @(negedge clk);
        #1 chk("ord_ready1", bus.req_ready, 4'b0010);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_res(n);
        chk("ord_latency", n, 17);
        chk("ord0_id", bus.res_id, 1);
        chk("ord0_xf", bus.res_xf, f_xf(0, 0));
        chk("ord0_yf", bus.res_yf, f_yf(0, 0));
        chk("ord0_angle", bus.res_angle, 0);
        @(negedge clk);
        chk("ord0_hold", bus.res_xf, 0);
        bus.res_ready = 1'b1;
        @(negedge clk) bus.res_ready = 1'b0;
        #1;
        chk("ord1_valid", bus.res_valid, 1);
        chk("ord1_id", bus.res_id, 1);
        chk("ord1_xf", bus.res_xf, 500);
        chk("ord1_yf", bus.res_yf, f_yf(-500, 0));
        chk("ord1_angle_const", bus.res_angle, 32'h0B40_0000);
        chk("ord1_angle", bus.res_angle, f_ang(-500, 0));
        @(negedge clk) bus.res_ready = 1'b1;
        @(negedge clk) bus.res_ready = 1'b0;
        #1 chk("ord_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cordic_vec_arbiter.md
Name: cordic_vec_arbiter

Overview:
- Shares one pipelined CORDIC vectoring core (fixed latency, one new vector per clock, no stall) among NREQ requesters.
- Round-robin arbitration on the input side; one issue per cycle.
- Tags every issued vector with its requester ID through a shift register matched to the core latency.
- Results land in an output FIFO; a credit counter guarantees the FIFO never overflows under res_ready backpressure.
- The core is instantiated by the parent; this block drives its inputs and samples its outputs.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 32, signed x/y width
- AW, 32, angle width (degrees, 12.20 unsigned fixed point; 45° = 32'h02D_00000)
- CORE_LAT, 17, clock edges from core input capture to valid core output
- FIFO_DEPTH, 32, result FIFO entries (power of 2); full throughput requires FIFO_DEPTH >= CORE_LAT+2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester vector valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_x  in  NREQ*W  packed x operands, requester i at [i*W +: W]
- req_y  in  NREQ*W  packed y operands
- core_x0  out  W  core x input
- core_y0  out  W  core y input
- core_xf  in  W  core magnitude output
- core_yf  in  W  core residual y output
- core_angle  in  AW  core angle output
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_id  out  $clog2(NREQ)  requester owning the result
- res_xf  out  W  magnitude
- res_yf  out  W  residual y
- res_angle  out  AW  angle
- busy  out  1  any vector in flight or any result queued

Behaviour:
- Reset (rst=0, asynchronous). Clears the tag pipe, FIFO pointers, occupancy counter and rr_ptr (to 0). Output values during reset:
  - req_ready = 0
  - res_valid = 0
  - busy = 0
  - core_x0 = core_y0 = 0
  - res_id, res_xf, res_yf and res_angle all 0
- Reset mid-flight: all in-flight and queued results are discarded. Core outputs are ignored until new tags arrive.
- Occupancy:
  - occ = vectors in tag pipe + FIFO entries, registered.
  - occ increments on accept and decrements on res_valid & res_ready.
  - A same-cycle accept and pop leaves occ unchanged.
- Credit: can_issue = (occ < FIFO_DEPTH), evaluated on registered occ only. A same-cycle pop does not create a credit.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ.
  - The first valid requester wins if can_issue.
  - req_ready[winner] = 1; all other bits 0.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Accept: req_valid[i] & req_ready[i].
  - On accept: rr_ptr <= (i+1) mod NREQ.
  - With no accept, rr_ptr holds.
- Core drive (combinational mux):
  - core_x0/core_y0 = req_x/req_y of the winner when accepting; otherwise 0.
  - The core captures on the accept edge.
- Tag pipe: CORE_LAT stages of {valid, id}. Stage 1 loads {accept, winner} on the accept edge; the pipe shifts every cycle unconditionally.
- Write: when stage CORE_LAT is valid, {id, core_xf, core_yf, core_angle} is written to the FIFO on the next edge. This is the edge CORE_LAT after the accept edge.
- FIFO:
  - Registered read data.
  - res_valid rises the cycle after the write edge when the FIFO was empty, so the accept edge to res_valid is CORE_LAT+1 edges.
  - Results stay in strict issue order.
- Result handshake:
  - res_* stay stable while res_valid & !res_ready.
  - Pop on res_valid & res_ready.
  - Simultaneous write and pop is supported at any occupancy, including empty (write-through) and full-1.
- Overflow cannot occur, given the credit rule. The bench asserts no write when the FIFO is full.
- busy = (occ != 0).

Decomposition:
- Shared package cordic_pkg:
  - CORDIC_LAT = 17
  - ANGLE_FRAC = 20
  - DEG45 = 32'h02D_00000
  - the result record typedef {id, xf, yf, angle}
- Sub-module cordic_res_fifo: synchronous FIFO with async active-low reset, registered output, depth/width parameters, full/empty/count.
- Arbiter and tag pipe stay in the top module.

Test Plan:
- Single request, requester 2, x=1000, y=1000 → req_ready[2] the same cycle; res_valid exactly 18 edges later. Checks: res_id=2; res_angle = 32'h02D_00000 ±16 LSB; res_xf = 1414 ±3; res_yf = 0 ±2.
- All 4 valid continuously, res_ready=1 → grants 0,1,2,3,0,… one per cycle with no bubble. res_id follows the same sequence 18 cycles later; 100 results with no gap.
- res_ready=0, requester 0 streaming → exactly 32 accepts, then req_ready=0. Raising res_ready for 1 cycle → one pop, and one new accept the following cycle (not the same cycle).
- Alternating req_valid on 1 and 3, with rr_ptr=2 → grant 3 first, then 1. Requester 0 is never granted.
- Reset asserted asynchronously mid-clock with 10 vectors in flight and 5 queued → res_valid, req_ready and busy drop immediately. After release: no stale results appear, and the first new request returns after 18 edges with the correct id.
- (0,0) and (-500,0) vectors from requester 1 → results are delivered in order with res_id=1. Data equals the core outputs sampled at the write edge, checked bit-exact against a core reference model.
